pc_fetch_ctrl: RTL
==================

Name: pc_fetch_ctrl

Overview:
- Instruction-fetch front end that holds the architectural PC and issues one fetch at a time to instruction memory.
- Delivers each instruction, tagged with its address, to decode over a valid/ready handshake.
- Takes the branch/jump target produced by the PC+imm target adder and redirects the fetch stream, discarding wrong-path fetches.
- `instrPC` is the PC that decode and the target adder consume.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset; must be word aligned.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- branchTaken  input  1  one-cycle redirect pulse from execute
- targetAddr  input  32  redirect target (PC+imm), sampled when branchTaken=1
- imReq  output  1  fetch request to instruction memory
- imAddr  output  32  fetch address, valid while imReq=1
- imGnt  input  1  memory accepts the request this cycle (imReq & imGnt)
- imRvalid  input  1  fetch data valid; exactly one per grant, at least 1 cycle after the grant
- imRdata  input  32  fetched instruction word
- instrValid  output  1  output buffer holds an instruction
- instr  output  32  buffered instruction
- instrPC  output  32  address of the buffered instruction
- decReady  input  1  decode accepts; transfer when instrValid & decReady
- misalign  output  1  only when PC_MISALIGN_CHK_EN is defined

Behaviour:
- Registers: pcReg (next fetch address), state, one-entry output buffer {instrValid, instr, instrPC}.
- Reset (asynchronous, any state, any time):
  - pcReg=RESET_VECTOR, state=BOOT.
  - imReq=0, instrValid=0, instr=0, instrPC=0, misalign=0.
  - A response arriving after reset from a pre-reset grant is ignored, because BOOT and REQ do not sample imRvalid.
- imAddr = pcReg combinationally. imAddr may change before a grant and is frozen only on the grant cycle.
- States:
  - BOOT: imReq=0; always moves to REQ next cycle. First request appears in the 2nd cycle after reset deassert.
  - REQ: imReq = (!instrValid | decReady). On imReq & imGnt go to WAIT; otherwise stay.
  - WAIT: imReq=0. On imRvalid: load instr=imRdata, instrPC=pcReg, instrValid=1; set pcReg=pcReg+4; go to REQ.
  - DROP: imReq=0. On imRvalid: discard the data, leave pcReg unchanged, go to REQ.
- Throughput: at most one instruction per 2 cycles. Only one request is outstanding at a time.
- Backpressure: gating imReq in REQ guarantees the buffer is empty, or drained that cycle, when the response arrives. A response therefore never meets a full buffer.
- Buffer drain: a transfer (instrValid & decReady) clears instrValid unless a load happens in the same cycle, in which case the load wins.
- Redirect (branchTaken=1) has priority over every other update:
  - pcReg <= targetAddr, and instrValid <= 0 (flush).
  - In BOOT: stay in BOOT.
  - In REQ: if imReq & imGnt in the same cycle, go to DROP (the old-address grant is consumed); otherwise stay in REQ, and the next request uses the target.
  - In WAIT: go to DROP. If imRvalid arrives in the same cycle, discard it and go to REQ.
  - In DROP: stay in DROP, or go to REQ if imRvalid arrives in the same cycle.
- Arithmetic: pcReg+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
- targetAddr is used unmodified; bits [1:0] are not masked.

Optional Feature:
- Macro PC_MISALIGN_CHK_EN.
- Defined:
  - On branchTaken with targetAddr[1:0]!=0: no redirect and no flush; misalign=1 from the next cycle.
  - While misalign=1, REQ drives imReq=0 and normal fetch is frozen.
  - A later aligned redirect clears misalign and resumes fetch normally.
  - Only reset or an aligned redirect clears misalign.
- Not defined: no misalign port; every target is taken as given.

Test Plan:
- Reset with RESET_VECTOR=32'h100, imGnt tied 1, rvalid 1 cycle after grant, decReady=1 → imAddr sequence 0x100, 0x104, 0x108; instrPC matches; one instrValid every 2 cycles.
- decReady=0 with buffer full → imReq stays 0 and instr/instrPC stay stable; raise decReady → request issued in that same cycle.
- branchTaken with targetAddr=32'h200 in the same cycle as imRvalid (WAIT) → data dropped, instrValid=0, next imAddr=0x200.
- branchTaken in WAIT, response 3 cycles later carrying 32'hDEADBEEF → never appears on instr; next fetch from target.
- pcReg=32'hFFFF_FFFC fetched → next imAddr=32'h0000_0000.
- With PC_MISALIGN_CHK_EN defined, targetAddr=32'h202 → misalign=1 and imReq=0; then aligned target 0x300 → misalign=0 and fetch at 0x300.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Purpose: instruction-fetch front end; holds the PC, keeps one memory request in flight, buffers one tagged instruction for decode.
// Latency: a request is issued the cycle after the previous response; the instruction is visible the cycle after imRvalid (at most one per 2 cycles).
// Backpressure: no request is issued unless the buffer is empty or draining that cycle, so a response never meets a full buffer.
// Optional: define PC_MISALIGN_CHK_EN to reject redirect targets with targetAddr[1:0]!=0 and raise misalign.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        branchTaken,
    input  logic [31:0] targetAddr,
    output logic        imReq,
    output logic [31:0] imAddr,
    input  logic        imGnt,
    input  logic        imRvalid,
    input  logic [31:0] imRdata,
    output logic        instrValid,
    output logic [31:0] instr,
    output logic [31:0] instrPC,
    input  logic        decReady
`ifdef PC_MISALIGN_CHK_EN
    ,
    output logic        misalign
`endif
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } stateT;

    stateT       state;
    stateT       stateNext;
    logic [31:0] pcReg;
    logic        redirect;
    logic        misalignQ;
    logic        grant;
    logic        load;

`ifdef PC_MISALIGN_CHK_EN
    // A misaligned target is refused outright: no redirect, no flush.
    assign redirect = branchTaken & (targetAddr[1:0] == 2'b00);

    // Sticky misalign flag: set by a refused target, cleared only by an aligned redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalignQ <= 1'b0;
        end else if (redirect) begin
            misalignQ <= 1'b0;
        end else if (branchTaken) begin
            misalignQ <= 1'b1;
        end
    end

    assign misalign = misalignQ;
`else
    assign redirect  = branchTaken;
    assign misalignQ = 1'b0;
`endif

    assign imAddr = pcReg;
    assign grant  = imReq & imGnt;
    // Only WAIT owns a live response; DROP and post-reset strays are never loaded.
    assign load   = (state == WAIT) & imRvalid & ~redirect;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= stateNext;
        end
    end

    // Next state and request generation; redirect turns an in-flight fetch into a dropped one.
    always_comb begin
        stateNext = state;
        imReq     = 1'b0;
        case (state)
            BOOT: begin
                stateNext = redirect ? BOOT : REQ;
            end
            REQ: begin
                imReq = (~instrValid | decReady) & ~misalignQ;
                if (imReq & imGnt) begin
                    stateNext = redirect ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (imRvalid) begin
                    stateNext = REQ;
                end else if (redirect) begin
                    stateNext = DROP;
                end
            end
            DROP: begin
                if (imRvalid) begin
                    stateNext = REQ;
                end
            end
            default: begin
                stateNext = BOOT;
            end
        endcase
    end

    // PC: redirect wins, otherwise advance by one word (mod 2^32) on every accepted instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcReg <= RESET_VECTOR;
        end else if (redirect) begin
            pcReg <= targetAddr;
        end else if (load) begin
            pcReg <= pcReg + 32'd4;
        end
    end

    // Output buffer: redirect flushes, a response loads (beating a same-cycle drain), a transfer drains.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instrValid <= 1'b0;
            instr      <= 32'h0;
            instrPC    <= 32'h0;
        end else if (redirect) begin
            instrValid <= 1'b0;
        end else if (load) begin
            instrValid <= 1'b1;
            instr      <= imRdata;
            instrPC    <= pcReg;
        end else if (instrValid & decReady) begin
            instrValid <= 1'b0;
        end
    end

    // Reading grant keeps the handshake term visible for waveform debug.
    logic unusedGrant;
    assign unusedGrant = grant;

endmodule
